// File: rtl/sha3_sponge_ctrl.sv
// Purpose: SHA3-256 sponge sequencer; absorbs 1088-bit rate blocks into a 1600-bit state and steps an external round function.
// Latency: block accepted on edge E0, rounds applied on E1..E24; blk_rdy (non-last) or digest_vld (last) high in the cycle after E24.
// Backpressure: blk_rdy low during permutation and while a digest waits; digest_vld is held until digest_rdy is seen at an edge.
`timescale 1ns/1ps
module sha3_sponge_ctrl #(
    parameter int RATE       = 1088,
    parameter int DIGEST_W   = 256,
    parameter int NUM_ROUNDS = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                blk_vld,
    input  logic                blk_last,
    input  logic [RATE-1:0]     blk_data,
    output logic                blk_rdy,
    output logic [1599:0]       rnd_state_o,
    output logic [4:0]          rnd_idx_o,
    input  logic [1599:0]       rnd_state_i,
    output logic [DIGEST_W-1:0] digest,
    output logic                digest_vld,
    input  logic                digest_rdy,
    output logic                busy
);

    localparam int          STATE_W  = 1600;
    localparam logic [4:0]  LAST_RND = 5'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PERM = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t               fsm_q;
    logic [STATE_W-1:0] state_q;
    logic [4:0]         rnd_q;
    logic               last_q;

    // Sponge sequencer: absorb on handshake, one round per cycle, hold digest until taken.
    // blk_rdy, busy and digest_vld are registered alongside the state so they change only on edges.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fsm_q      <= IDLE;
            state_q    <= '0;
            rnd_q      <= 5'd0;
            last_q     <= 1'b0;
            blk_rdy    <= 1'b1;
            busy       <= 1'b0;
            digest_vld <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (blk_vld && blk_rdy) begin
                        // Only the rate part absorbs input; capacity bits pass through untouched.
                        state_q <= {state_q[STATE_W-1:RATE], state_q[RATE-1:0] ^ blk_data};
                        last_q  <= blk_last;
                        rnd_q   <= 5'd0;
                        fsm_q   <= PERM;
                        blk_rdy <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                PERM: begin
                    state_q <= rnd_state_i;
                    if (rnd_q == LAST_RND) begin
                        rnd_q <= 5'd0;
                        if (last_q) begin
                            fsm_q      <= DONE;
                            digest_vld <= 1'b1;
                        end else begin
                            // Mid-message: state is kept so the next block chains onto it.
                            fsm_q   <= IDLE;
                            blk_rdy <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end else begin
                        rnd_q <= rnd_q + 5'd1;
                    end
                end
                DONE: begin
                    if (digest_rdy) begin
                        // Handoff ends the message; clear so the next message starts from zero.
                        state_q    <= '0;
                        last_q     <= 1'b0;
                        fsm_q      <= IDLE;
                        digest_vld <= 1'b0;
                        blk_rdy    <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    fsm_q      <= IDLE;
                    blk_rdy    <= 1'b1;
                    busy       <= 1'b0;
                    digest_vld <= 1'b0;
                end
            endcase
        end
    end

    // Round function inputs are zeroed outside PERM so it sees no activity while idle.
    assign rnd_state_o = (fsm_q == PERM) ? state_q : '0;
    assign rnd_idx_o   = (fsm_q == PERM) ? rnd_q   : 5'd0;

    // Digest is the low lanes of the state; only meaningful while digest_vld is high.
    assign digest = state_q[DIGEST_W-1:0];

endmodule
